trace_src_arbiter: RTL and testbench
====================================

Name: trace_src_arbiter

Overview:
Shares the single trace FIFO write port between num_src_p independent trace sources. Each source gets a one-entry holding register and a saturating drop counter. A round-robin scheduler drives one registered valid/ready output toward the FIFO. Each output word is tagged with a source id and a record type: sample or drop-count. Sits between the per-probe sample taps and the trace FIFO.

Parameters:
num_src_p, 4, number of trace sources (>=2)
sample_width_p, 16, bits per sample
counter_width_p, 16, drop counter width; must be <= sample_width_p
id_width_lp (local), max(1,$clog2(num_src_p)), source id field width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
sample_data  in  num_src_p*sample_width_p  source i data in slice [i*sample_width_p +: sample_width_p]
sample_valid  in  num_src_p  per-source sample strobe; no ready, a sample is taken or counted as dropped
src_enable  in  num_src_p  per-source enable; 0 = source ignored entirely
fifo_data  out  1+id_width_lp+sample_width_p  {is_drop, src_id, payload}
fifo_valid  out  1  output word valid
fifo_ready  in  1  FIFO can accept

Behaviour:
- Clock/reset: one clock (clk); reset synchronous, active-high.
- Reset: fifo_valid=0, fifo_data=0, all hold_v=0, all drop_ctr=0, rr_ptr=0. Reset mid-transfer discards held words and counts; no flush.
- Per-source state: hold_v[i], hold_d[i], drop_ctr[i].
- Request: req[i] = src_enable[i] && (hold_v[i] || drop_ctr[i]!=0).
- Record selection for a granted source:
  - hold_v=1: emit sample record {0, i, hold_d[i]}; clear hold_v.
  - else: emit drop record {1, i, zero-extended drop_ctr[i]}; clear drop_ctr.
  - Resulting order per source: held sample, then its drop record, then newer samples.
- Output load: out_free = !fifo_valid || fifo_ready.
  - If out_free && |req: pick grant, register the record into fifo_data, fifo_valid=1.
  - If out_free && no req: fifo_valid=0; fifo_data holds its last value.
  - fifo_data/fifo_valid are stable while fifo_valid && !fifo_ready.
- Round robin: grant goes to the first requester at or after rr_ptr (wrapping). On a grant, rr_ptr <= grant+1 mod num_src_p. rr_ptr is unchanged when nothing is granted.
- Capture, evaluated per source each cycle when sample_valid[i] && src_enable[i]:
  - can_take = (!hold_v[i] || sample granted this cycle) && (drop_ctr[i]==0 || drop granted this cycle).
  - can_take: hold_d <= sample, hold_v <= 1. This gives single-cycle back-to-back throughput when granted.
  - else: drop_ctr[i] <= drop_ctr[i]+1, saturating at all-ones. The clear-by-grant and an increment never happen in the same cycle, because a grant makes can_take true.
- Latency: sample to fifo_valid is 2 cycles minimum (hold register, then output register).
- src_enable deasserted with a pending hold or count: state is retained but not requested. It is emitted after re-enable.
- Simultaneous: all sources valid every cycle with fifo_ready=1 -> each source is served once per num_src_p cycles. Other samples are counted as drops.

Optional Feature:
Macro TRACE_SRC_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index requester wins; rr_ptr is removed.
- Undefined: round robin as above.
- Record format, capture and drop rules are identical in both modes.

Test Plan:
- Single source: reset, fifo_ready=1, src0 sample 0x1234 at cycle 0 -> cycle 2 fifo_valid=1, fifo_data={0,0,0x1234}; one-cycle pulse.
- Drop accounting: fifo_ready=0, src1 sends 0xA,0xB,0xC,0xD on consecutive cycles; then fifo_ready=1 -> outputs {0,1,0x000A} then {1,1,0x0003}; no further records.
- Saturation (counter_width_p=4): fifo_ready=0 with src2 held, 20 further samples -> drop record payload 0x000F.
- Round robin: all 4 sources continuously valid, fifo_ready=1 -> src_id sequence 0,1,2,3,0,... Drop records appear interleaved per source, and no source is skipped.
- Backpressure stall: fifo_valid=1 and fifo_ready=0 for 5 cycles -> fifo_data unchanged every cycle; new samples are counted, not lost silently.
- Reset mid-operation: pending holds and counts on all sources, assert reset 1 cycle -> fifo_valid=0 next cycle; no stale records emitted afterward.

Source files
------------

// File: rtl/trace_src_arbiter.sv
// trace_src_arbiter: per-source one-entry hold + saturating drop counter,
// arbitrated onto one registered valid/ready port toward the trace FIFO.
// Optional macro TRACE_SRC_ARB_FIXED_PRIO_EN selects lowest-index-wins
// arbitration instead of round robin.
module trace_src_arbiter #(
    parameter int num_src_p       = 4,
    parameter int sample_width_p  = 16,
    parameter int counter_width_p = 16,
    localparam int id_width_lp  = (num_src_p <= 2) ? 1 : $clog2(num_src_p),
    localparam int rec_width_lp = 1 + id_width_lp + sample_width_p
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [num_src_p*sample_width_p-1:0] sample_data,
    input  logic [num_src_p-1:0]                sample_valid,
    input  logic [num_src_p-1:0]                src_enable,
    output logic [rec_width_lp-1:0]             fifo_data,
    output logic                                fifo_valid,
    input  logic                                fifo_ready
);

    logic [num_src_p-1:0]       hold_v;
    logic [sample_width_p-1:0]  hold_d   [num_src_p];
    logic [counter_width_p-1:0] drop_ctr [num_src_p];

    logic [num_src_p-1:0]       req;
    logic [num_src_p-1:0]       sample_gnt;
    logic [num_src_p-1:0]       drop_gnt;
    logic [num_src_p-1:0]       can_take;
    logic                       out_free;
    logic                       gnt_any;
    logic [id_width_lp-1:0]     grant;
    logic [rec_width_lp-1:0]    rec;

    assign out_free = !fifo_valid || fifo_ready;
    assign gnt_any  = out_free && (|req);

    // A source requests while it has a held sample or a nonzero drop count
    always_comb begin
        req = '0;
        for (int i = 0; i < num_src_p; i++) begin
            req[i] = src_enable[i] && (hold_v[i] || (drop_ctr[i] != '0));
        end
    end

`ifdef TRACE_SRC_ARB_FIXED_PRIO_EN
    // Lowest-index requester wins
    always_comb begin
        grant = '0;
        for (int k = num_src_p - 1; k >= 0; k--) begin
            if (req[k]) grant = id_width_lp'(k);
        end
    end
`else
    logic [id_width_lp-1:0] rr_ptr;
    logic [id_width_lp:0]   rr_sum;
    logic                   rr_found;

    // First requester at or after rr_ptr, wrapping at num_src_p
    always_comb begin
        grant    = '0;
        rr_sum   = '0;
        rr_found = 1'b0;
        for (int k = 0; k < num_src_p; k++) begin
            rr_sum = {1'b0, rr_ptr} + (id_width_lp + 1)'(k);
            if (rr_sum >= (id_width_lp + 1)'(num_src_p)) begin
                rr_sum = rr_sum - (id_width_lp + 1)'(num_src_p);
            end
            if (!rr_found && req[rr_sum[id_width_lp-1:0]]) begin
                rr_found = 1'b1;
                grant    = rr_sum[id_width_lp-1:0];
            end
        end
    end

    // Pointer moves just past the winner; it holds when nothing is granted
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (gnt_any) begin
            if (grant == id_width_lp'(num_src_p - 1)) rr_ptr <= '0;
            else                                     rr_ptr <= grant + 1'b1;
        end
    end
`endif

    // Held sample goes out before its drop record; newer samples wait behind both
    always_comb begin
        sample_gnt = '0;
        drop_gnt   = '0;
        can_take   = '0;
        for (int i = 0; i < num_src_p; i++) begin
            sample_gnt[i] = gnt_any && (grant == id_width_lp'(i)) && hold_v[i];
            drop_gnt[i]   = gnt_any && (grant == id_width_lp'(i)) && !hold_v[i];
            can_take[i]   = (!hold_v[i] || sample_gnt[i]) &&
                            ((drop_ctr[i] == '0) || drop_gnt[i]);
        end
    end

    // Build the record for the granted source
    always_comb begin
        if (hold_v[grant]) begin
            rec = {1'b0, grant, hold_d[grant]};
        end else begin
            rec = {1'b1, grant, sample_width_p'(drop_ctr[grant])};
        end
    end

    // Per-source capture; a grant frees the slot for a same-cycle sample
    always_ff @(posedge clk) begin
        for (int i = 0; i < num_src_p; i++) begin
            if (reset) begin
                hold_v[i]   <= 1'b0;
                hold_d[i]   <= '0;
                drop_ctr[i] <= '0;
            end else begin
                if (sample_gnt[i]) hold_v[i] <= 1'b0;
                if (drop_gnt[i])   drop_ctr[i] <= '0;
                if (sample_valid[i] && src_enable[i]) begin
                    if (can_take[i]) begin
                        hold_v[i] <= 1'b1;
                        hold_d[i] <= sample_data[i*sample_width_p +: sample_width_p];
                    end else if (drop_ctr[i] != '1) begin
                        drop_ctr[i] <= drop_ctr[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Output register only reloads when empty or being accepted
    always_ff @(posedge clk) begin
        if (reset) begin
            fifo_valid <= 1'b0;
            fifo_data  <= '0;
        end else if (out_free) begin
            fifo_valid <= gnt_any;
            if (gnt_any) fifo_data <= rec;
        end
    end

endmodule

// File: tb/tb_trace_src_arbiter.sv
// tb_trace_src_arbiter: directed + random stimulus, record-level reference
// model feeding a scoreboard queue checked by an independent monitor.
module tb_trace_src_arbiter;

    localparam int NS   = 4;
    localparam int SW   = 16;
    localparam int CW   = 4;
    localparam int IW   = 2;
    localparam int DW   = 1 + IW + SW;
    localparam int CMAX = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [NS*SW-1:0] sample_data;
    logic [NS-1:0]    sample_valid;
    logic [NS-1:0]    src_enable;
    logic [DW-1:0]    fifo_data;
    logic             fifo_valid;
    logic             fifo_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trace_src_arbiter #(
        .num_src_p      (NS),
        .sample_width_p (SW),
        .counter_width_p(CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_data (sample_data),
        .sample_valid(sample_valid),
        .src_enable  (src_enable),
        .fifo_data   (fifo_data),
        .fifo_valid  (fifo_valid),
        .fifo_ready  (fifo_ready)
    );

    // reference state: what each source still owes the FIFO
    bit            m_hold_v [NS];
    logic [SW-1:0] m_hold_d [NS];
    int            m_cnt    [NS];
    bit            m_out_v;
    int            m_ptr;

    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] got_q [$];
    bit            mon_en = 1'b0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step();
        int win;
        int s;
        bit free;
        logic [DW-1:0] r;
        if (reset) begin
            for (int i = 0; i < NS; i++) begin
                m_hold_v[i] = 1'b0;
                m_cnt[i]    = 0;
            end
            m_out_v = 1'b0;
            m_ptr   = 0;
            exp_q.delete();
            return;
        end
        free = !m_out_v || fifo_ready;
        win  = -1;
        if (free) begin
            for (int k = 0; k < NS; k++) begin
                s = (m_ptr + k) % NS;
                if (win < 0 && src_enable[s] && (m_hold_v[s] || m_cnt[s] != 0))
                    win = s;
            end
            if (win >= 0) begin
                if (m_hold_v[win]) begin
                    r = {1'b0, IW'(win), m_hold_d[win]};
                    m_hold_v[win] = 1'b0;
                end else begin
                    r = {1'b1, IW'(win), SW'(m_cnt[win])};
                    m_cnt[win] = 0;
                end
                exp_q.push_back(r);
                m_out_v = 1'b1;
`ifndef TRACE_SRC_ARB_FIXED_PRIO_EN
                m_ptr = (win + 1) % NS;
`endif
            end else begin
                m_out_v = 1'b0;
            end
        end
        // a new sample fits only once nothing older is owed by that source
        for (int i = 0; i < NS; i++) begin
            if (sample_valid[i] && src_enable[i]) begin
                if (!m_hold_v[i] && m_cnt[i] == 0) begin
                    m_hold_v[i] = 1'b1;
                    m_hold_d[i] = sample_data[i*SW +: SW];
                end else if (m_cnt[i] < CMAX) begin
                    m_cnt[i]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic push(int s, logic [SW-1:0] d);
        sample_valid[s]         = 1'b1;
        sample_data[s*SW +: SW] = d;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid", {31'b0, fifo_valid}, {31'b0, m_out_v});
            if (fifo_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL data: got 0x%0h expected no word", fifo_data);
                end else begin
                    check("data", 32'(fifo_data), 32'(exp_q[0]));
                    if (fifo_ready) void'(exp_q.pop_front());
                end
                if (fifo_ready) got_q.push_back(fifo_data);
            end
        end
    end

    initial begin
        logic [SW-1:0] vals [4];
        int n_drop;
        vals = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};

        reset        = 1'b1;
        sample_valid = '0;
        sample_data  = '0;
        src_enable   = '1;
        fifo_ready   = 1'b0;
        tick();
        tick();
        mon_en = 1'b1;
        check("reset_valid", {31'b0, fifo_valid}, 32'd0);
        check("reset_data", 32'(fifo_data), 32'd0);
        reset = 1'b0;

        // single source latency and one-cycle pulse
        fifo_ready = 1'b1;
        push(0, 16'h1234);
        tick();
        sample_valid = '0;
        tick();
        check("t1_valid", {31'b0, fifo_valid}, 32'd1);
        check("t1_data", 32'(fifo_data), 32'h01234);
        tick();
        check("t1_pulse", {31'b0, fifo_valid}, 32'd0);

        // drop accounting behind a stalled output word
        got_q.delete();
        fifo_ready = 1'b0;
        push(3, 16'h5555);
        tick();
        sample_valid = '0;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) push(1, vals[k]);
            else       sample_valid = '0;
            tick();
            check("stall_valid", {31'b0, fifo_valid}, 32'd1);
            check("stall_data", 32'(fifo_data), 32'h35555);
        end
        sample_valid = '0;
        fifo_ready   = 1'b1;
        repeat (4) tick();
        check("t2_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("t2_w0", 32'(got_q[0]), 32'h35555);
            check("t2_w1", 32'(got_q[1]), 32'h1000A);
            check("t2_w2", 32'(got_q[2]), 32'h50003);
        end

        // drop counter saturation
        got_q.delete();
        fifo_ready = 1'b0;
        push(2, 16'h2220);
        tick();
        for (int k = 1; k <= 21; k++) begin
            push(2, 16'h2220 + SW'(k));
            tick();
        end
        sample_valid = '0;
        fifo_ready   = 1'b1;
        repeat (5) tick();
        check("t3_count", got_q.size(), 32'd3);
        if (got_q.size() == 3) begin
            check("t3_w1", 32'(got_q[1]), 32'h22221);
            check("t3_sat", 32'(got_q[2]), 32'h6000F);
        end

        // all sources saturating the port
        reset = 1'b1;
        tick();
        reset = 1'b0;
        got_q.delete();
        fifo_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            for (int s = 0; s < NS; s++) push(s, SW'($urandom));
            tick();
        end
        sample_valid = '0;
        repeat (8) tick();
        check("t4_min_words", {31'b0, got_q.size() >= 16}, 32'd1);
        n_drop = 0;
        for (int j = 0; j < got_q.size(); j++) begin
            if (got_q[j][DW-1]) n_drop++;
`ifndef TRACE_SRC_ARB_FIXED_PRIO_EN
            if (j < 16) check("t4_rr_id", 32'(got_q[j][SW +: IW]), 32'(j % NS));
`endif
        end
        check("t4_has_drop", {31'b0, n_drop > 0}, 32'd1);

        // reset with pending holds and counts everywhere
        fifo_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            for (int s = 0; s < NS; s++) push(s, SW'($urandom));
            tick();
        end
        reset = 1'b1;
        tick();
        check("t5_valid", {31'b0, fifo_valid}, 32'd0);
        check("t5_data", 32'(fifo_data), 32'd0);
        reset        = 1'b0;
        sample_valid = '0;
        fifo_ready   = 1'b1;
        got_q.delete();
        repeat (10) tick();
        check("t5_no_stale", got_q.size(), 32'd0);

        // randomized traffic with enables, backpressure and resets
        for (int c = 0; c < 3000; c++) begin
            sample_data  = {$urandom, $urandom};
            sample_valid = NS'($urandom);
            for (int s = 0; s < NS; s++)
                src_enable[s] = ($urandom_range(0, 99) < 85);
            fifo_ready = ($urandom_range(0, 99) < 55);
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset        = 1'b0;
        sample_valid = '0;
        src_enable   = '1;
        fifo_ready   = 1'b1;
        repeat (20) tick();
        check("drain_empty", exp_q.size(), 32'd0);
        check("drain_idle", {31'b0, fifo_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
